// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D memory arbiter: RAM handshake state, word type,
// arbiter FSM encoding and default starvation settings.
package mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        IGNT = 2'b01,
        DGNT = 2'b10
    } arb_state_t;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int CNT_W_DEF        = 3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/response and RAM-side bus signals around the arbiter.
// slave = the arbiter's view; master = the caches plus RAM around it.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      iwait;
    logic      dwait;
    word_t     iload;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      mem_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
    );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access. Data wins,
// but after STARVE_LIMIT data grants taken while a fetch waits, fetch is forced.
//
// state | meaning
// IDLE  | no owner, RAM enables off, both waits high
// IGNT  | instruction fetch owns the RAM until ACCESS or abort
// DGNT  | data access owns the RAM until ACCESS or abort
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input logic         CLK,
    input logic         nRST,
    mem_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t       state, next_state;
    logic [CNT_W-1:0] starve_cnt, next_cnt;
    logic             d_req, owner_req, done;

    always_comb begin
        d_req     = bus.dREN | bus.dWEN;
        owner_req = 1'b0;
        if (state == IGNT) owner_req = bus.iREN;
        if (state == DGNT) owner_req = d_req;
        done      = owner_req && (bus.ramstate == ACCESS);
    end

    always_comb begin
        next_state = state;
        next_cnt   = starve_cnt;
        case (state)
            IDLE: begin
                if (d_req && !(bus.iREN && starve_cnt == LIMIT)) begin
                    next_state = DGNT;
                    if (!bus.iREN)
                        next_cnt = '0;
                    else if (starve_cnt != LIMIT)
                        next_cnt = starve_cnt + CNT_W'(1);
                end else if (bus.iREN) begin
                    next_state = IGNT;
                    next_cnt   = '0;
                end
            end
            IGNT, DGNT: begin
                // A dropped request (flush) aborts the grant without a wait pulse.
                if (!owner_req || done)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= next_state;
            starve_cnt <= next_cnt;
        end
    end

    // Outputs decode the registered state so an async reset drops enables at once.
    always_comb begin
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.mem_err  = owner_req && (bus.ramstate == ERROR);
        case (state)
            IGNT: begin
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = bus.iREN;
                if (done) begin
                    bus.iwait = 1'b0;
                    bus.iload = bus.ramload;
                end
            end
            DGNT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                if (done) begin
                    bus.dwait = 1'b0;
                    bus.dload = bus.ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a grant-ownership model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int LIMIT    = 4;
    localparam int OWN_NONE = 0;
    localparam int OWN_I    = 1;
    localparam int OWN_D    = 2;

    logic CLK = 1'b0;
    logic nRST;
    int   total = 0;
    int   bad   = 0;

    // reference model: who owns the RAM, and how many data grants in a row
    // were taken while a fetch was waiting
    int m_own    = OWN_NONE;
    int m_streak = 0;
    bit m_active;
    bit m_done;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.iREN     = 1'b0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.iaddr    = '0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = FREE;
    endtask

    task automatic model_reset();
        m_own    = OWN_NONE;
        m_streak = 0;
    endtask

    // Wait for the falling edge and compare every output with the model.
    task automatic sample();
        bit    i_act, d_act;
        logic  e_ren, e_wen;
        word_t e_addr, e_store;
        @(negedge CLK);
        i_act    = (m_own == OWN_I) && bus.iREN;
        d_act    = (m_own == OWN_D) && (bus.dREN || bus.dWEN);
        m_active = i_act || d_act;
        m_done   = m_active && (bus.ramstate == ACCESS);
        e_ren    = 1'b0;
        e_wen    = 1'b0;
        e_addr   = '0;
        e_store  = '0;
        if (m_own == OWN_I) begin
            e_ren  = bus.iREN;
            e_addr = bus.iaddr;
        end
        if (m_own == OWN_D) begin
            e_wen   = bus.dWEN;
            e_ren   = bus.dREN && !bus.dWEN;
            e_addr  = bus.daddr;
            e_store = bus.dstore;
        end
        chk1 ("iwait",    bus.iwait,   !(i_act && m_done));
        chk1 ("dwait",    bus.dwait,   !(d_act && m_done));
        chk32("iload",    bus.iload,   (i_act && m_done) ? bus.ramload : 32'h0);
        chk32("dload",    bus.dload,   (d_act && m_done) ? bus.ramload : 32'h0);
        chk1 ("ramREN",   bus.ramREN,  e_ren);
        chk1 ("ramWEN",   bus.ramWEN,  e_wen);
        chk32("ramaddr",  bus.ramaddr, e_addr);
        chk32("ramstore", bus.ramstore, e_store);
        chk1 ("mem_err",  bus.mem_err, m_active && (bus.ramstate == ERROR));
    endtask

    // Apply the grant rules to the model, then move to just after the next rising edge.
    task automatic advance();
        if (m_own == OWN_NONE) begin
            if ((bus.dREN || bus.dWEN) && !(bus.iREN && m_streak >= LIMIT)) begin
                m_own    = OWN_D;
                m_streak = bus.iREN ? ((m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1) : 0;
            end else if (bus.iREN) begin
                m_own    = OWN_I;
                m_streak = 0;
            end
        end else if (!m_active || m_done) begin
            m_own = OWN_NONE;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    initial begin
        word_t ld;
        int    n_d, n_i;
        idle_inputs();
        nRST = 1'b0;
        model_reset();

        // reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk1 ("rst_iwait",  bus.iwait,  1'b1);
        chk1 ("rst_dwait",  bus.dwait,  1'b1);
        chk1 ("rst_ramREN", bus.ramREN, 1'b0);
        chk1 ("rst_ramWEN", bus.ramWEN, 1'b0);
        chk1 ("rst_state",  dut.state == IDLE, 1'b1);
        @(posedge CLK);
        #1 nRST = 1'b1;
        cyc();

        // lone fetch, two BUSY cycles before ACCESS
        bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = BUSY;
        sample(); chk1("fetch_c1_iwait", bus.iwait, 1'b1); advance();
        sample(); chk1("fetch_c2_ren", bus.ramREN, 1'b1);
        chk32("fetch_c2_addr", bus.ramaddr, 32'h40); advance();
        sample(); chk1("fetch_c3_iwait", bus.iwait, 1'b1); advance();
        ld = $urandom; bus.ramload = ld; bus.ramstate = ACCESS;
        sample(); chk1("fetch_c4_iwait", bus.iwait, 1'b0);
        chk32("fetch_c4_iload", bus.iload, ld); advance();
        idle_inputs(); cyc();

        // simultaneous requests: data first, one IDLE, then fetch
        bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dREN = 1'b1; bus.daddr = 32'h100;
        bus.ramstate = ACCESS; bus.ramload = 32'h1234_5678;
        sample(); advance();
        sample(); chk1("simul_dwait", bus.dwait, 1'b0); chk1("simul_iwait_hi", bus.iwait, 1'b1);
        chk32("simul_daddr", bus.ramaddr, 32'h100); advance();
        bus.dREN = 1'b0;
        sample(); chk1("simul_gap_iwait", bus.iwait, 1'b1); chk1("simul_gap_ren", bus.ramREN, 1'b0); advance();
        sample(); chk1("simul_iwait", bus.iwait, 1'b0); advance();
        idle_inputs(); cyc();

        // starvation: fetch held, data re-requested every cycle
        bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.dREN = 1'b1; bus.daddr = 32'h180;
        bus.ramstate = ACCESS;
        n_d = 0; n_i = 0;
        for (int c = 0; c < 10; c++) begin
            sample();
            if (bus.dwait === 1'b0 && n_i == 0) n_d++;
            if (bus.iwait === 1'b0) begin
                n_i++;
                chk32("starve_cnt_cleared", 32'(dut.starve_cnt), 32'h0);
            end
            advance();
        end
        chk32("starve_d_grants", n_d, 32'd4);
        chk32("starve_i_grants", n_i, 32'd1);
        idle_inputs(); cyc(); cyc();

        // write wins over read
        bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'hDEADBEEF;
        bus.ramstate = BUSY;
        cyc();
        sample(); chk1("wr_wen", bus.ramWEN, 1'b1); chk1("wr_ren", bus.ramREN, 1'b0);
        chk32("wr_store", bus.ramstore, 32'hDEADBEEF); chk32("wr_addr", bus.ramaddr, 32'h200); advance();
        bus.ramstate = ACCESS;
        sample(); chk1("wr_done", bus.dwait, 1'b0); advance();
        idle_inputs(); cyc();

        // abort during BUSY
        bus.dREN = 1'b1; bus.daddr = 32'h300; bus.ramstate = BUSY;
        cyc();
        sample(); chk1("abort_ren_before", bus.ramREN, 1'b1); advance();
        bus.dREN = 1'b0;
        sample(); chk1("abort_ren_drop", bus.ramREN, 1'b0); chk1("abort_dwait", bus.dwait, 1'b1); advance();
        sample(); chk1("abort_idle", dut.state == IDLE, 1'b1); chk1("abort_dwait2", bus.dwait, 1'b1); advance();

        // RAM error retried with the grant held
        bus.dREN = 1'b1; bus.ramstate = FREE;
        cyc();
        bus.ramstate = ERROR;
        sample(); chk1("err_pulse", bus.mem_err, 1'b1); chk1("err_dwait", bus.dwait, 1'b1); advance();
        bus.ramstate = BUSY;
        sample(); chk1("err_pulse_end", bus.mem_err, 1'b0); chk1("err_held", bus.ramREN, 1'b1);
        chk1("err_state", dut.state == DGNT, 1'b1); advance();
        bus.ramstate = ACCESS;
        sample(); chk1("err_retry_done", bus.dwait, 1'b0); advance();
        idle_inputs(); cyc();

        // reset in the middle of a fetch
        bus.iREN = 1'b1; bus.iaddr = 32'h500; bus.ramstate = BUSY;
        cyc();
        sample(); chk1("rstmid_ren_before", bus.ramREN, 1'b1);
        #2 nRST = 1'b0;
        #1;
        chk1("rstmid_ren", bus.ramREN, 1'b0);
        chk1("rstmid_state", dut.state == IDLE, 1'b1);
        model_reset();
        @(posedge CLK);
        #1 nRST = 1'b1;
        idle_inputs(); cyc();

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            bus.iREN     = ($urandom_range(0, 3) != 0);
            bus.dREN     = ($urandom_range(0, 2) != 0);
            bus.dWEN     = ($urandom_range(0, 3) == 0);
            bus.iaddr    = $urandom;
            bus.daddr    = $urandom;
            bus.dstore   = $urandom;
            bus.ramload  = $urandom;
            bus.ramstate = ramstate_t'($urandom_range(0, 3));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
